// File: rtl/path_stack.sv
// path_stack: direction stack for the maze solver that replays the recorded path first-to-last over valid/ready.
module path_stack #(
  parameter int DEPTH = 256,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] dIn,
  input  logic          done,
  input  logic          moveRdy,
  output logic          empStck,
  output logic          full,
  output logic [DW-1:0] topDir,
  output logic          moveValid,
  output logic [DW-1:0] moveDir,
  output logic          moveLast,
  output logic          pathDone,
  output logic          ovf,
  output logic          unf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] STACK = 2'd0, REPLAY = 2'd1, FIN = 2'd2;
  localparam logic [AW-1:0] ONE = 1;
  localparam logic [AW:0] SP_ONE = 1;
  logic [1:0] state;
  logic [AW:0] sp;
  logic [AW-1:0] rp, top_idx, wr_idx;
  logic [DW-1:0] mem [DEPTH];
  logic replace, wr_en;
  // sp==DEPTH wraps the low bits to 0, so top_idx still lands on DEPTH-1
  assign top_idx = sp[AW-1:0] - ONE;
  assign empStck = sp == '0;
  assign full = sp[AW];
  assign topDir = empStck ? '0 : mem[top_idx];
  assign moveValid = state == REPLAY;
  assign moveDir = moveValid ? mem[rp] : '0;
  assign moveLast = moveValid && rp == top_idx;
  assign pathDone = state == FIN;
  assign replace = push && pop && !empStck;
  assign wr_en = state == STACK && !start && !done && push && (replace || !full);
  assign wr_idx = replace ? top_idx : sp[AW-1:0];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_idx] <= dIn;
  always_ff @(posedge clk or posedge rst) begin
    if (rst || start) begin
      state <= STACK;
      sp <= '0;
      rp <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (state == STACK) begin
      if (done) begin
        rp <= '0;
        state <= empStck ? FIN : REPLAY;
      end else if (replace) begin
        sp <= sp;
      end else if (push) begin
        if (full) ovf <= 1'b1;
        else sp <= sp + SP_ONE;
      end else if (pop) begin
        if (empStck) unf <= 1'b1;
        else sp <= sp - SP_ONE;
      end
    end else if (state == REPLAY && moveRdy) begin
      rp <= rp + ONE;
      if (moveLast) state <= FIN;
    end
  end
endmodule

// File: tb/tb_path_stack.sv
// tb_path_stack: directed and random checks of path_stack against a queue-based reference model.
module tb_path_stack;
  localparam int D = 4, W = 2;
  logic clk = 0, rst = 1, start = 0, push = 0, pop = 0, done = 0, moveRdy = 0;
  logic [W-1:0] dIn = 0;
  logic empStck, full, moveValid, moveLast, pathDone, ovf, unf;
  logic [W-1:0] topDir, moveDir;
  int errs = 0, checks = 0;
  int stk[$];
  int mst = 0, rp = 0;
  bit m_ovf = 0, m_unf = 0;

  path_stack #(.DEPTH(D), .DW(W)) dut (
    .clk(clk), .rst(rst), .start(start), .push(push), .pop(pop), .dIn(dIn),
    .done(done), .moveRdy(moveRdy), .empStck(empStck), .full(full),
    .topDir(topDir), .moveValid(moveValid), .moveDir(moveDir),
    .moveLast(moveLast), .pathDone(pathDone), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // mst: 0 = collecting moves, 1 = replaying, 2 = finished
  task automatic chk_all(input string tag);
    int n = stk.size();
    chk({tag, ".empStck"}, 8'(empStck), 8'(n == 0));
    chk({tag, ".full"}, 8'(full), 8'(n == D));
    chk({tag, ".topDir"}, 8'(topDir), n != 0 ? 8'(stk[n-1]) : 8'd0);
    chk({tag, ".moveValid"}, 8'(moveValid), 8'(mst == 1));
    chk({tag, ".moveDir"}, 8'(moveDir), mst == 1 ? 8'(stk[rp]) : 8'd0);
    chk({tag, ".moveLast"}, 8'(moveLast), 8'(mst == 1 && rp == n - 1));
    chk({tag, ".pathDone"}, 8'(pathDone), 8'(mst == 2));
    chk({tag, ".ovf"}, 8'(ovf), 8'(m_ovf));
    chk({tag, ".unf"}, 8'(unf), 8'(m_unf));
  endtask

  task automatic model_reset();
    stk.delete();
    mst = 0;
    rp = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic step();
    if (rst || start) model_reset();
    else if (mst == 0) begin
      if (done) begin
        rp = 0;
        mst = stk.size() != 0 ? 1 : 2;
      end else if (push && pop && stk.size() != 0) stk[stk.size()-1] = int'(dIn);
      else if (push) begin
        if (stk.size() == D) m_ovf = 1;
        else stk.push_back(int'(dIn));
      end else if (pop) begin
        if (stk.size() == 0) m_unf = 1;
        else void'(stk.pop_back());
      end
    end else if (mst == 1 && moveRdy) begin
      if (rp == stk.size() - 1) mst = 2;
      rp++;
    end
  endtask

  task automatic cyc(input string tag, input logic s, input logic pu, input logic po,
                     input logic [W-1:0] d, input logic dn, input logic r);
    start = s; push = pu; pop = po; dIn = d; done = dn; moveRdy = r;
    @(posedge clk);
    step();
    @(negedge clk);
    chk_all(tag);
  endtask

  initial begin
    int hs, n;
    logic [W-1:0] held;
    #2 chk_all("reset");
    @(negedge clk);
    rst = 0;
    cyc("idle", 0, 0, 0, 0, 0, 0);
    // four pushes, one pop, replay with consumer always ready
    cyc("t1p0", 0, 1, 0, 2'b01, 0, 0);
    cyc("t1p1", 0, 1, 0, 2'b10, 0, 0);
    cyc("t1p2", 0, 1, 0, 2'b11, 0, 0);
    cyc("t1p3", 0, 1, 0, 2'b00, 0, 0);
    cyc("t1pop", 0, 0, 1, 0, 0, 0);
    cyc("t1done", 0, 0, 0, 0, 1, 1);
    chk("t1.firstmove", 8'(moveDir), 8'h1);
    cyc("t1m1", 0, 0, 0, 0, 0, 1);
    cyc("t1m2", 0, 0, 0, 0, 0, 1);
    chk("t1.lastdir", 8'(moveDir), 8'h3);
    cyc("t1m3", 0, 0, 0, 0, 0, 1);
    chk("t1.pathDone", 8'(pathDone), 8'h1);
    cyc("t1ign", 0, 1, 1, 2'b10, 1, 1);
    // replace top, then underflow
    cyc("t2start", 1, 0, 0, 0, 0, 0);
    cyc("t2p", 0, 1, 0, 2'b01, 0, 0);
    cyc("t2rep", 0, 1, 1, 2'b10, 0, 0);
    chk("t2.topDir", 8'(topDir), 8'h2);
    cyc("t2pop", 0, 0, 1, 0, 0, 0);
    cyc("t2unf", 0, 0, 1, 0, 0, 0);
    chk("t2.unf", 8'(unf), 8'h1);
    cyc("t2pp_empty", 0, 1, 1, 2'b11, 0, 0);
    // fill and overflow
    cyc("t3start", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("t3push", 0, 1, 0, W'(i + 1), 0, 0);
    chk("t3.ovf", 8'(ovf), 8'h1);
    chk("t3.topDir", 8'(topDir), 8'h0);
    // replay with stalls
    cyc("t4start", 1, 0, 0, 0, 0, 0);
    cyc("t4p0", 0, 1, 0, 2'b11, 0, 0);
    cyc("t4p1", 0, 1, 0, 2'b01, 0, 0);
    cyc("t4p2", 0, 1, 0, 2'b10, 0, 0);
    cyc("t4done", 0, 0, 0, 0, 1, 0);
    hs = 0;
    foreach (stk[i]) begin end
    for (int i = 0; i < 6; i++) begin
      logic r;
      r = (6'b110010 >> (5 - i)) & 1'b1;
      held = moveDir;
      if (moveValid && r) hs++;
      cyc("t4rdy", 0, 0, 0, 0, 0, r);
      if (!r && mst == 1) chk("t4.hold", 8'(moveDir), 8'(held));
    end
    chk("t4.handshakes", 8'(hs), 8'd3);
    // empty replay
    cyc("t5start", 1, 0, 0, 0, 0, 0);
    cyc("t5done", 0, 0, 0, 0, 1, 1);
    chk("t5.pathDone", 8'(pathDone), 8'h1);
    cyc("t5start2", 1, 0, 0, 0, 0, 0);
    // async reset in the middle of the second move
    cyc("t6p0", 0, 1, 0, 2'b10, 0, 0);
    cyc("t6p1", 0, 1, 0, 2'b01, 0, 0);
    cyc("t6done", 0, 0, 0, 0, 1, 0);
    cyc("t6m1", 0, 0, 0, 0, 0, 1);
    moveRdy = 0;
    #1 rst = 1;
    #1 model_reset();
    chk_all("t6async");
    cyc("t6hold", 0, 0, 0, 0, 0, 0);
    rst = 0;
    cyc("t6p", 0, 1, 0, 2'b11, 0, 0);
    cyc("t6d", 0, 0, 0, 0, 1, 1);
    cyc("t6m", 0, 0, 0, 0, 0, 1);
    // random rounds
    for (int k = 0; k < 40; k++) begin
      cyc("rstart", 1, 0, 0, 0, 0, 0);
      n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++)
        cyc("rstk", 0, 1'($urandom), 1'($urandom_range(0, 2) == 0), W'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom));
      cyc("rdone", 0, 1'($urandom), 1'($urandom), W'($urandom), 1, 1'($urandom));
      for (int i = 0; i < 30 && mst == 1; i++)
        cyc("rrep", 1'($urandom_range(0, 40) == 0), 1'($urandom), 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      chk("rnd.settled", 8'(mst == 1), 8'd0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
